mmu_unit: RTL and testbench
===========================

// Module: mmu_unit
// PURPOSE
//  Address-translation unit sitting between the CPU core and the data bus.
//  - Translates the core's 32-bit virtual address into a physical bus address.
//  - Flags I/O (uncached) regions and raises translation exceptions.
//  - Exposes TLB/control registers to the core through a register/command port.
//  - The bus sequencer pulses addrValid once per access; results appear registered one cycle later.
// PARAMETERS
//  TLB_ENTRIES  16  number of fully-associative TLB entries (power of 2, <=32)
// PORTS
//  clk             in   1   clock, rising edge
//  res             in   1   reset, asynchronous, active-high
//  addrValid       in   1   capture vAddr/mmu_accessType and translate this cycle
//  vAddr           in   32  virtual address from core
//  mmu_accessType  in   2   `MEM_ACCESS: NONE=0 R=1 W=2 X=3
//  pAddr           out  32  translated physical address (registered)
//  db_io           out  1   1 = uncached/I/O target (registered)
//  mmu_exception   out  3   `MMU_EXCEPTION: NONE=0 MISS=1 INVALID=2 MODIFIED=3 ADDR_ERR=4
//  mmu_reg         in   3   `MMU_REG select: INDEX=0 ENTRYHI=1 ENTRYLO=2 BADVADDR=3
//  mmu_cmd         in   3   `MMU_CMD: NONE=0 WRITE_REG=1 TLBWI=2 TLBR=3 TLBP=4
//  mmu_dataIn      in   32  data written by core (WRITE_REG)
//  mmu_dataOut     out  32  combinational read of register selected by mmu_reg
// BEHAVIOUR
//  Reset: pAddr=0, db_io=0, mmu_exception=NONE; INDEX/ENTRYHI/ENTRYLO/BADVADDR=0; all TLB V bits=0.
//  Translation occurs on the clk edge where addrValid=1 (latency 1). Outputs hold until the next addrValid.
//  Segment rules:
//   - vAddr[31:29]=100 (0x8000_0000-0x9FFF_FFFF): pAddr={3'b0,vAddr[28:0]}, db_io=0, no TLB.
//   - vAddr[31:29]=101 (0xA000_0000-0xBFFF_FFFF): same mapping, db_io=1.
//   - All other addresses: mapped through the TLB, 4 KiB pages.
//  TLB entry fields: VPN[19:0], PFN[19:0], N (io), D (dirty/writable), V (valid).
//   - Match: VPN==vAddr[31:12]. Multiple matches resolve to the lowest index.
//  Exception priority:
//   1. ADDR_ERR: access X with vAddr[1:0]!=0.
//   2. MISS: no matching entry.
//   3. INVALID: matching entry has V=0.
//   4. MODIFIED: access W and D=0.
//   5. Otherwise NONE, pAddr={PFN,vAddr[11:0]}, db_io=N.
//  On any exception: BADVADDR<=vAddr, pAddr<=vAddr, db_io<=0.
//  addrValid with mmu_accessType=NONE: translate anyway. ADDR_ERR and MODIFIED checks are skipped.
//  Registers and commands:
//   - ENTRYHI[31:12]=VPN, low bits read 0.
//   - ENTRYLO[31:12]=PFN, [2]=N, [1]=D, [0]=V.
//   - INDEX[31]=probe-fail flag, [log2 N-1:0]=index.
//   - WRITE_REG writes mmu_dataIn to the selected register at the clk edge. BADVADDR is read-only (write ignored).
//   - TLBWI: TLB[INDEX] <= {ENTRYHI,ENTRYLO}.
//   - TLBR: ENTRYHI/ENTRYLO <= TLB[INDEX].
//   - TLBP: on ENTRYHI match, INDEX<={0,idx}; on miss, INDEX<=32'h8000_0000.
//   - Commands execute in one cycle. An undefined cmd acts as NONE.
//  Simultaneous events:
//   - addrValid with a TLB command in the same cycle: translation uses pre-command TLB/registers.
//   - If an exception would also load BADVADDR during a WRITE_REG, the exception load wins.
//  Reset mid-operation clears everything immediately; no pending state survives.
// STRUCTURE
//  Shared package (mmu.vh/DataBus.vh): `MMU_REG, `MMU_CMD, `MMU_EXCEPTION, `MEM_ACCESS widths and codes above.
//  Sub-module mmu_tlb: entry array + combinational match (hit, idx, entry) used for both vAddr lookup and TLBP.
//  Top level holds the registers, segment decode, exception priority and output flops.
// TESTING
//  - Reset, then addrValid vAddr=0x8000_1234 R -> pAddr=0x0000_1234, db_io=0, exc=NONE.
//  - vAddr=0xA000_0010 R -> pAddr=0x0000_0010, db_io=1, exc=NONE.
//  - vAddr=0x0040_0000 R, empty TLB -> exc=MISS(1), BADVADDR reads 0x0040_0000.
//  - Program an entry:
//    - write ENTRYHI=0x0040_0000, ENTRYLO=0x0123_4003, INDEX=5, then TLBWI.
//    - vAddr=0x0040_0ABC R -> pAddr=0x0123_4ABC, exc=NONE.
//    - TLBP -> INDEX=5.
//  - Same entry rewritten with ENTRYLO=0x0123_4001:
//    - W to 0x0040_0000 -> MODIFIED(3).
//    - ENTRYLO=0x0123_4000 -> INVALID(2).
//    - X to 0x8000_0002 -> ADDR_ERR(4).
//  - TLBP with ENTRYHI=0x7FFF_F000 unmapped -> INDEX=0x8000_0000. Assert res mid-access -> all outputs 0/NONE.

Source files
------------

// File: rtl/mmu_unit_pkg.sv
// mmu_unit_pkg: register/command/exception/access codes and TLB entry layout shared by the MMU.
package mmu_unit_pkg;
   typedef enum logic [2:0] {REG_INDEX, REG_ENTRYHI, REG_ENTRYLO, REG_BADVADDR} mmu_reg_e;
   typedef enum logic [2:0] {CMD_NONE, CMD_WRITE_REG, CMD_TLBWI, CMD_TLBR, CMD_TLBP} mmu_cmd_e;
   typedef enum logic [2:0] {EXC_NONE, EXC_MISS, EXC_INVALID, EXC_MODIFIED, EXC_ADDR_ERR} mmu_exc_e;
   typedef enum logic [1:0] {ACC_NONE, ACC_R, ACC_W, ACC_X} mem_access_e;
   typedef struct packed {
      logic [19:0] vpn;
      logic [19:0] pfn;
      logic        n;
      logic        d;
      logic        v;
   } tlb_entry_t;
endpackage

// File: rtl/mmu_unit_tlb.sv
// mmu_unit_tlb: fully-associative TLB array with a translation lookup, a probe lookup and an indexed read/write port.
module mmu_unit_tlb
   import mmu_unit_pkg::*;
#(
   parameter int ENTRIES = 16,
   localparam int IW = $clog2(ENTRIES)
) (
   input  logic          clk,
   input  logic          res,
   input  logic          we,
   input  logic [IW-1:0] idx,
   input  tlb_entry_t    wdata,
   output tlb_entry_t    rdata,
   input  logic [19:0]   vpn_a,
   output logic          hit_a,
   output tlb_entry_t    ent_a,
   input  logic [19:0]   vpn_b,
   output logic          hit_b,
   output logic [IW-1:0] idx_b
);
   tlb_entry_t tlb [ENTRIES];
   always_ff @(posedge clk or posedge res)
      if (res)
         for (int i = 0; i < ENTRIES; i++) tlb[i] <= '0;
      else if (we)
         tlb[idx] <= wdata;
   assign rdata = tlb[idx];
   // Scan downwards so the lowest matching index is the one left standing.
   always_comb begin
      hit_a = 1'b0;
      ent_a = '0;
      hit_b = 1'b0;
      idx_b = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (tlb[i].vpn == vpn_a) begin
            hit_a = 1'b1;
            ent_a = tlb[i];
         end
         if (tlb[i].vpn == vpn_b) begin
            hit_b = 1'b1;
            idx_b = IW'(i);
         end
      end
   end
endmodule

// File: rtl/mmu_unit.sv
// mmu_unit: virtual-to-physical translation with segment decode, TLB lookup, exception priority and CP0-style registers.
module mmu_unit
   import mmu_unit_pkg::*;
#(
   parameter int TLB_ENTRIES = 16
) (
   input  logic        clk,
   input  logic        res,
   input  logic        addrValid,
   input  logic [31:0] vAddr,
   input  logic [1:0]  mmu_accessType,
   output logic [31:0] pAddr,
   output logic        db_io,
   output logic [2:0]  mmu_exception,
   input  logic [2:0]  mmu_reg,
   input  logic [2:0]  mmu_cmd,
   input  logic [31:0] mmu_dataIn,
   output logic [31:0] mmu_dataOut
);
   localparam int IW = $clog2(TLB_ENTRIES);
   logic [19:0]   hi_vpn, lo_pfn;
   logic          lo_n, lo_d, lo_v, idx_p;
   logic [IW-1:0] idx, idx_b;
   logic [31:0]   badvaddr, pa;
   logic          hit_a, hit_b, unmapped, addr_err, io;
   tlb_entry_t    ent_a, rdata;
   mmu_exc_e      exc;
   logic          unused;
   mmu_unit_tlb #(.ENTRIES(TLB_ENTRIES)) u_tlb (
      .clk   (clk),
      .res   (res),
      .we    (mmu_cmd == CMD_TLBWI),
      .idx   (idx),
      .wdata ({hi_vpn, lo_pfn, lo_n, lo_d, lo_v}),
      .rdata (rdata),
      .vpn_a (vAddr[31:12]),
      .hit_a (hit_a),
      .ent_a (ent_a),
      .vpn_b (hi_vpn),
      .hit_b (hit_b),
      .idx_b (idx_b)
   );
   assign unused = ^{mmu_dataIn, ent_a.vpn};
   // 0x8000_0000-0xBFFF_FFFF bypass the TLB; bit 29 selects the uncached half.
   always_comb begin
      unmapped = vAddr[31:30] == 2'b10;
      addr_err = mmu_accessType == ACC_X && vAddr[1:0] != 2'b00;
      exc = addr_err ? EXC_ADDR_ERR :
            unmapped ? EXC_NONE :
            !hit_a ? EXC_MISS :
            !ent_a.v ? EXC_INVALID :
            (mmu_accessType == ACC_W && !ent_a.d) ? EXC_MODIFIED : EXC_NONE;
      pa = exc != EXC_NONE ? vAddr : unmapped ? {3'b000, vAddr[28:0]} : {ent_a.pfn, vAddr[11:0]};
      io = exc == EXC_NONE && (unmapped ? vAddr[29] : ent_a.n);
   end
   always_comb
      mmu_dataOut = mmu_reg == REG_INDEX    ? {idx_p, {(31-IW){1'b0}}, idx} :
                    mmu_reg == REG_ENTRYHI  ? {hi_vpn, 12'h000} :
                    mmu_reg == REG_ENTRYLO  ? {lo_pfn, 9'h000, lo_n, lo_d, lo_v} :
                    mmu_reg == REG_BADVADDR ? badvaddr : 32'h0;
   // Translation sees the pre-command register/TLB state since everything updates on the same edge.
   always_ff @(posedge clk or posedge res)
      if (res) begin
         pAddr         <= '0;
         db_io         <= 1'b0;
         mmu_exception <= EXC_NONE;
         hi_vpn        <= '0;
         lo_pfn        <= '0;
         {lo_n, lo_d, lo_v} <= '0;
         idx_p         <= 1'b0;
         idx           <= '0;
         badvaddr      <= '0;
      end else begin
         if (addrValid) begin
            pAddr         <= pa;
            db_io         <= io;
            mmu_exception <= exc;
         end
         if (mmu_cmd == CMD_WRITE_REG && mmu_reg == REG_INDEX) {idx_p, idx} <= {mmu_dataIn[31], mmu_dataIn[IW-1:0]};
         if (mmu_cmd == CMD_WRITE_REG && mmu_reg == REG_ENTRYHI) hi_vpn <= mmu_dataIn[31:12];
         if (mmu_cmd == CMD_WRITE_REG && mmu_reg == REG_ENTRYLO) {lo_pfn, lo_n, lo_d, lo_v} <= {mmu_dataIn[31:12], mmu_dataIn[2:0]};
         if (mmu_cmd == CMD_TLBR) {hi_vpn, lo_pfn, lo_n, lo_d, lo_v} <= rdata;
         if (mmu_cmd == CMD_TLBP) {idx_p, idx} <= hit_b ? {1'b0, idx_b} : {1'b1, {IW{1'b0}}};
         if (addrValid && exc != EXC_NONE) badvaddr <= vAddr;
      end
endmodule

// File: tb/tb_mmu_unit.sv
// tb_mmu_unit: table-driven translation vectors checked through a scoreboard queue, plus register/command sequences.
module tb_mmu_unit;
   localparam logic [2:0] R_IDX = 0, R_HI = 1, R_LO = 2, R_BAD = 3;
   localparam logic [2:0] C_NONE = 0, C_WR = 1, C_TLBWI = 2, C_TLBR = 3, C_TLBP = 4;
   localparam logic [1:0] A_N = 0, A_R = 1, A_W = 2, A_X = 3;
   logic        clk = 0, res = 1, addrValid = 0, db_io;
   logic [31:0] vAddr = 0, pAddr, mmu_dataIn = 0, mmu_dataOut;
   logic [1:0]  mmu_accessType = 0;
   logic [2:0]  mmu_exception, mmu_reg = 0, mmu_cmd = 0;
   typedef struct {
      logic [31:0] pa;
      logic        io;
      logic [2:0]  exc;
   } exp_t;
   typedef struct {
      logic [31:0] va;
      logic [1:0]  at;
      logic [31:0] pa;
      logic        io;
      logic [2:0]  exc;
   } vec_t;
   exp_t q[$];
   exp_t e;
   vec_t va_tab[7];
   vec_t vb_tab[6];
   int n = 0, nerr = 0;
   mmu_unit dut (
      .clk(clk), .res(res), .addrValid(addrValid), .vAddr(vAddr), .mmu_accessType(mmu_accessType),
      .pAddr(pAddr), .db_io(db_io), .mmu_exception(mmu_exception), .mmu_reg(mmu_reg),
      .mmu_cmd(mmu_cmd), .mmu_dataIn(mmu_dataIn), .mmu_dataOut(mmu_dataOut)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic step(input logic av, input logic [31:0] va, input logic [1:0] at,
                       input logic [2:0] cmd, input logic [2:0] rg, input logic [31:0] din);
      @(negedge clk);
      addrValid = av;
      vAddr = va;
      mmu_accessType = at;
      mmu_cmd = cmd;
      mmu_reg = rg;
      mmu_dataIn = din;
   endtask
   task automatic accx(input logic [31:0] va, input logic [1:0] at, input logic [31:0] pa, input logic io,
                       input logic [2:0] exc, input logic [2:0] cmd, input logic [2:0] rg, input logic [31:0] din);
      exp_t x;
      x.pa = pa;
      x.io = io;
      x.exc = exc;
      q.push_back(x);
      step(1'b1, va, at, cmd, rg, din);
   endtask
   task automatic acc(input logic [31:0] va, input logic [1:0] at, input logic [31:0] pa, input logic io, input logic [2:0] exc);
      accx(va, at, pa, io, exc, C_NONE, R_IDX, 32'h0);
   endtask
   task automatic wr(input logic [2:0] rg, input logic [31:0] din);
      step(1'b0, 32'h0, A_N, C_WR, rg, din);
   endtask
   task automatic cmd(input logic [2:0] c);
      step(1'b0, 32'h0, A_N, c, R_IDX, 32'h0);
   endtask
   task automatic rd(input string name, input logic [2:0] rg, input logic [31:0] exp);
      step(1'b0, 32'h0, A_N, C_NONE, rg, 32'h0);
      #1 chk(name, mmu_dataOut, exp);
   endtask
   // Each translation pops its expectation one cycle after the capturing edge.
   always @(posedge clk)
      if (addrValid && !res) begin
         #1;
         if (q.size() == 0) begin
            n++;
            nerr++;
            $display("FAIL scoreboard: unexpected result pAddr=%h with no expectation queued", pAddr);
         end else begin
            e = q.pop_front();
            chk($sformatf("pAddr@%h", vAddr), pAddr, e.pa);
            chk($sformatf("db_io@%h", vAddr), {31'h0, db_io}, {31'h0, e.io});
            chk($sformatf("exc@%h", vAddr), {29'h0, mmu_exception}, {29'h0, e.exc});
         end
      end
   initial begin
      va_tab[0] = '{32'h8000_1234, A_R, 32'h0000_1234, 1'b0, 3'd0};
      va_tab[1] = '{32'hA000_0010, A_R, 32'h0000_0010, 1'b1, 3'd0};
      va_tab[2] = '{32'h9FFF_FFFC, A_X, 32'h1FFF_FFFC, 1'b0, 3'd0};
      va_tab[3] = '{32'h8000_0002, A_X, 32'h8000_0002, 1'b0, 3'd4};
      va_tab[4] = '{32'h8000_0002, A_N, 32'h0000_0002, 1'b0, 3'd0};
      va_tab[5] = '{32'hBFFF_F003, A_W, 32'h1FFF_F003, 1'b1, 3'd0};
      va_tab[6] = '{32'h0040_0000, A_R, 32'h0040_0000, 1'b0, 3'd1};
      vb_tab[0] = '{32'h0040_0ABC, A_R, 32'h0123_4ABC, 1'b0, 3'd0};
      vb_tab[1] = '{32'h0040_0ABC, A_W, 32'h0123_4ABC, 1'b0, 3'd0};
      vb_tab[2] = '{32'h0040_0004, A_X, 32'h0123_4004, 1'b0, 3'd0};
      vb_tab[3] = '{32'h0040_0001, A_X, 32'h0040_0001, 1'b0, 3'd4};
      vb_tab[4] = '{32'h0040_1000, A_R, 32'h0040_1000, 1'b0, 3'd1};
      vb_tab[5] = '{32'h003F_FFFC, A_R, 32'h003F_FFFC, 1'b0, 3'd1};
      #12;
      chk("reset pAddr", pAddr, 32'h0);
      chk("reset db_io", {31'h0, db_io}, 32'h0);
      chk("reset exc", {29'h0, mmu_exception}, 32'h0);
      @(negedge clk) res = 0;
      for (int r = 0; r < 4; r++) rd($sformatf("reset reg%0d", r), 3'(r), 32'h0);
      foreach (va_tab[i]) acc(va_tab[i].va, va_tab[i].at, va_tab[i].pa, va_tab[i].io, va_tab[i].exc);
      rd("badvaddr after miss", R_BAD, 32'h0040_0000);
      wr(R_BAD, 32'hDEAD_BEEF);
      rd("badvaddr read-only", R_BAD, 32'h0040_0000);
      wr(R_HI, 32'h0040_0FFF);
      rd("entryhi low bits", R_HI, 32'h0040_0000);
      wr(R_LO, 32'h0123_4FFB);
      rd("entrylo fields", R_LO, 32'h0123_4003);
      wr(R_IDX, 32'h7FFF_FFF5);
      rd("index fields", R_IDX, 32'h0000_0005);
      cmd(C_TLBWI);
      foreach (vb_tab[i]) acc(vb_tab[i].va, vb_tab[i].at, vb_tab[i].pa, vb_tab[i].io, vb_tab[i].exc);
      wr(R_IDX, 32'h0);
      cmd(C_TLBP);
      rd("tlbp hit 5", R_IDX, 32'h0000_0005);
      wr(R_LO, 32'h0765_4007);
      wr(R_IDX, 32'h2);
      cmd(C_TLBWI);
      acc(32'h0040_0010, A_R, 32'h0765_4010, 1'b1, 3'd0);
      cmd(C_TLBP);
      rd("tlbp lowest index", R_IDX, 32'h0000_0002);
      wr(R_HI, 32'h0050_0000);
      wr(R_LO, 32'h0);
      cmd(C_TLBWI);
      acc(32'h0040_0010, A_R, 32'h0123_4010, 1'b0, 3'd0);
      acc(32'h0050_0000, A_R, 32'h0050_0000, 1'b0, 3'd2);
      wr(R_IDX, 32'h5);
      cmd(C_TLBR);
      rd("tlbr entryhi", R_HI, 32'h0040_0000);
      rd("tlbr entrylo", R_LO, 32'h0123_4003);
      wr(R_LO, 32'h0123_4001);
      cmd(C_TLBWI);
      acc(32'h0040_0000, A_W, 32'h0040_0000, 1'b0, 3'd3);
      acc(32'h0040_0000, A_R, 32'h0123_4000, 1'b0, 3'd0);
      acc(32'h0040_0000, A_N, 32'h0123_4000, 1'b0, 3'd0);
      wr(R_LO, 32'h0123_4000);
      cmd(C_TLBWI);
      acc(32'h0040_0000, A_R, 32'h0040_0000, 1'b0, 3'd2);
      acc(32'h0040_0002, A_X, 32'h0040_0002, 1'b0, 3'd4);
      acc(32'h8000_0002, A_X, 32'h8000_0002, 1'b0, 3'd4);
      rd("badvaddr addr_err", R_BAD, 32'h8000_0002);
      wr(R_HI, 32'h7FFF_F000);
      cmd(C_TLBP);
      rd("tlbp miss", R_IDX, 32'h8000_0000);
      wr(R_HI, 32'h0060_0000);
      wr(R_LO, 32'h0ABC_D003);
      wr(R_IDX, 32'h7);
      accx(32'h0060_0004, A_R, 32'h0060_0004, 1'b0, 3'd1, C_TLBWI, R_IDX, 32'h0);
      acc(32'h0060_0004, A_R, 32'h0ABC_D004, 1'b0, 3'd0);
      accx(32'h0070_0000, A_R, 32'h0070_0000, 1'b0, 3'd1, C_WR, R_BAD, 32'h0000_1234);
      cmd(C_NONE);
      cmd(C_NONE);
      chk("hold pAddr", pAddr, 32'h0070_0000);
      chk("hold exc", {29'h0, mmu_exception}, 32'h1);
      rd("exception beats write", R_BAD, 32'h0070_0000);
      acc(32'hA000_0010, A_R, 32'h0000_0010, 1'b1, 3'd0);
      step(1'b1, 32'h0040_0ABC, A_R, C_NONE, R_HI, 32'h0);
      #2 res = 1;
      #1;
      chk("midreset pAddr", pAddr, 32'h0);
      chk("midreset db_io", {31'h0, db_io}, 32'h0);
      chk("midreset exc", {29'h0, mmu_exception}, 32'h0);
      chk("midreset entryhi", mmu_dataOut, 32'h0);
      @(negedge clk);
      res = 0;
      addrValid = 0;
      acc(32'h0060_0004, A_R, 32'h0060_0004, 1'b0, 3'd1);
      rd("post-reset badvaddr", R_BAD, 32'h0060_0004);
      if (q.size() != 0) begin
         n++;
         nerr++;
         $display("FAIL scoreboard drain: %0d expectations left, expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
      $finish;
   end
endmodule
